// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: buffered stereo sample serialiser for a codec-mastered I2S DAC link.
// Define I2S_DAC_TX_LEFT_JUSTIFIED_EN to emit left-justified framing instead of I2S.
module i2s_dac_tx #(
   parameter int SAMPLE_W    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_50mhz,
   input  logic                reset_n,
   input  logic [SAMPLE_W-1:0] audio_in_left,
   input  logic [SAMPLE_W-1:0] audio_in_right,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic                aud_bclk,
   input  logic                aud_daclrck,
   output logic                aud_dacdat,
   output logic                frame_strobe,
   output logic                underrun
);

   localparam int               CNT_W   = $clog2(SAMPLE_W + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_W + 1);
`ifdef I2S_DAC_TX_LEFT_JUSTIFIED_EN
   localparam logic [CNT_W-1:0] DATA_END         = CNT_W'(SAMPLE_W);
   localparam logic             ALIGN_DRIVES_MSB = 1'b1;
`else
   localparam logic [CNT_W-1:0] DATA_END         = CNT_W'(SAMPLE_W + 1);
   localparam logic             ALIGN_DRIVES_MSB = 1'b0;
`endif

   logic [1:0] pin_async;
   logic [1:0] pin_synced;
   logic [1:0] pin_hist;

   assign pin_async = {aud_daclrck, aud_bclk};

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;

      always_ff @(posedge clk_50mhz or negedge reset_n) begin
         if (!reset_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
         end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_async[gi]};
            hist_reg <= sync_reg[SYNC_STAGES-1];
         end
      end

      assign pin_synced[gi] = sync_reg[SYNC_STAGES-1];
      assign pin_hist[gi]   = hist_reg;
   end

   logic bclk_fall;
   logic lr_fall;
   logic lr_rise;
   logic lr_edge;
   logic lrck_synced;

   assign bclk_fall   = pin_hist[0] & ~pin_synced[0];
   assign lr_fall     = pin_hist[1] & ~pin_synced[1];
   assign lr_rise     = ~pin_hist[1] & pin_synced[1];
   assign lr_edge     = lr_fall | lr_rise;
   assign lrck_synced = pin_synced[1];

   logic                buf_full_reg,    buf_full_next;
   logic [SAMPLE_W-1:0] buf_left_reg,    buf_left_next;
   logic [SAMPLE_W-1:0] buf_right_reg,   buf_right_next;
   logic [SAMPLE_W-1:0] left_shift_reg,  left_shift_next;
   logic [SAMPLE_W-1:0] right_shift_reg, right_shift_next;
   logic [CNT_W-1:0]    bit_cnt_reg,     bit_cnt_next;
   logic                dacdat_reg,      dacdat_next;
   logic                strobe_reg,      strobe_next;
   logic                underrun_reg,    underrun_next;
   logic                accept;
   logic                shift_now;

   assign accept = sample_valid & ~buf_full_reg;

   always_comb begin
      buf_full_next    = buf_full_reg;
      buf_left_next    = buf_left_reg;
      buf_right_next   = buf_right_reg;
      left_shift_next  = left_shift_reg;
      right_shift_next = right_shift_reg;
      bit_cnt_next     = bit_cnt_reg;
      dacdat_next      = dacdat_reg;
      strobe_next      = 1'b0;
      underrun_next    = 1'b0;
      shift_now        = 1'b0;

      // A producer arriving exactly at frame start bypasses the empty buffer.
      if (lr_fall) begin
         if (buf_full_reg) begin
            left_shift_next  = buf_left_reg;
            right_shift_next = buf_right_reg;
            buf_full_next    = 1'b0;
            strobe_next      = 1'b1;
         end else if (sample_valid) begin
            left_shift_next  = audio_in_left;
            right_shift_next = audio_in_right;
            strobe_next      = 1'b1;
         end else begin
            left_shift_next  = '0;
            right_shift_next = '0;
            underrun_next    = 1'b1;
         end
      end else if (accept) begin
         buf_left_next  = audio_in_left;
         buf_right_next = audio_in_right;
         buf_full_next  = 1'b1;
      end

      if (lr_edge) begin
         bit_cnt_next = '0;
         dacdat_next  = 1'b0;
      end

      // Count 0 means the next fall is the alignment edge of the slot.
      if (bclk_fall) begin
         if (lr_edge || bit_cnt_reg == '0) begin
            bit_cnt_next = CNT_W'(1);
            shift_now    = ALIGN_DRIVES_MSB;
         end else begin
            shift_now = (bit_cnt_reg < DATA_END);
            if (bit_cnt_reg != CNT_MAX) begin
               bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            end
         end
         dacdat_next = 1'b0;
         if (shift_now) begin
            if (lrck_synced) begin
               dacdat_next      = right_shift_next[SAMPLE_W-1];
               right_shift_next = {right_shift_next[SAMPLE_W-2:0], 1'b0};
            end else begin
               dacdat_next     = left_shift_next[SAMPLE_W-1];
               left_shift_next = {left_shift_next[SAMPLE_W-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         buf_full_reg    <= 1'b0;
         buf_left_reg    <= '0;
         buf_right_reg   <= '0;
         left_shift_reg  <= '0;
         right_shift_reg <= '0;
         bit_cnt_reg     <= '0;
         dacdat_reg      <= 1'b0;
         strobe_reg      <= 1'b0;
         underrun_reg    <= 1'b0;
      end else begin
         buf_full_reg    <= buf_full_next;
         buf_left_reg    <= buf_left_next;
         buf_right_reg   <= buf_right_next;
         left_shift_reg  <= left_shift_next;
         right_shift_reg <= right_shift_next;
         bit_cnt_reg     <= bit_cnt_next;
         dacdat_reg      <= dacdat_next;
         strobe_reg      <= strobe_next;
         underrun_reg    <= underrun_next;
      end
   end

   assign sample_ready = ~buf_full_reg;
   assign aud_dacdat   = dacdat_reg;
   assign frame_strobe = strobe_reg;
   assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: codec-side model drives bclk/lrck (64 bclk per frame) and checks every sampled bit.
// Honours I2S_DAC_TX_LEFT_JUSTIFIED_EN for the expected framing.
module tb_i2s_dac_tx;

   logic        clk_50mhz = 1'b0;
   logic        reset_n;
   logic [15:0] audio_in_left;
   logic [15:0] audio_in_right;
   logic        sample_valid;
   logic        sample_ready;
   logic        aud_bclk;
   logic        aud_daclrck;
   logic        aud_dacdat;
   logic        frame_strobe;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   logic        pend_valid = 1'b0;
   logic [15:0] pend_l = '0, pend_r = '0;
   logic [15:0] cur_l = '0, cur_r = '0;
   logic        exp_ready = 1'b1;
   int          exp_strobe = 0, exp_under = 0;
   int          strobe_cnt = 0, under_cnt = 0;
   int          frame_no = -1;
   int          cur_slot = 0, cur_bit = 0;
   bit          codec_run = 1'b0;
   bit          have_prev = 1'b0;
   int          prev_slot = 0, prev_frame = 0;
   logic [31:0] cap = '0;
   logic [31:0] pin_val;
   event        ev_fall;

   i2s_dac_tx dut (
      .clk_50mhz      (clk_50mhz),
      .reset_n        (reset_n),
      .audio_in_left  (audio_in_left),
      .audio_in_right (audio_in_right),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .aud_bclk       (aud_bclk),
      .aud_daclrck    (aud_daclrck),
      .aud_dacdat     (aud_dacdat),
      .frame_strobe   (frame_strobe),
      .underrun       (underrun)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bit b of a slot counts sampling rises from the one following the lrck change.
   function automatic logic exp_bit(input logic [15:0] w, input int b);
`ifdef I2S_DAC_TX_LEFT_JUSTIFIED_EN
      if (b < 16) return w[15-b];
`else
      if (b >= 1 && b <= 16) return w[16-b];
`endif
      return 1'b0;
   endfunction

   function automatic bit pinned(input int fr, input int sl, output logic [31:0] val);
      val = '0;
`ifdef I2S_DAC_TX_LEFT_JUSTIFIED_EN
      if (fr == 0 && sl == 0) begin val = 32'h8001_0000; return 1'b1; end
      if (fr == 0 && sl == 1) begin val = 32'h7FFE_0000; return 1'b1; end
      if (fr == 3 && sl == 0) begin val = 32'hA5A5_0000; return 1'b1; end
      if (fr == 13 && sl == 0) begin val = 32'h1234_0000; return 1'b1; end
`else
      if (fr == 0 && sl == 0) begin val = 32'h4000_8000; return 1'b1; end
      if (fr == 0 && sl == 1) begin val = 32'h3FFF_0000; return 1'b1; end
      if (fr == 3 && sl == 0) begin val = 32'h52D2_8000; return 1'b1; end
      if (fr == 13 && sl == 0) begin val = 32'h091A_0000; return 1'b1; end
`endif
      if (fr == 1 && sl == 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(negedge clk_50mhz);
      if (frame_strobe === 1'b1) strobe_cnt++;
      if (underrun === 1'b1) under_cnt++;
   endtask

   initial begin : codec
      aud_bclk    = 1'b1;
      aud_daclrck = 1'b1;
      wait (codec_run);
      forever begin
         for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < 32; b++) begin
               tick();
               aud_bclk = 1'b0;
               if (b == 0) begin
                  aud_daclrck = (s == 1);
                  if (have_prev && pinned(prev_frame, prev_slot, pin_val))
                     check($sformatf("slot_word_f%0d_s%0d", prev_frame, prev_slot), cap, pin_val);
                  cap = '0;
                  if (s == 0) begin
                     frame_no++;
                     strobe_cnt = 0;
                     under_cnt  = 0;
                     if (pend_valid) begin
                        cur_l = pend_l; cur_r = pend_r; pend_valid = 1'b0;
                        exp_strobe = 1; exp_under = 0;
                     end else begin
                        cur_l = '0; cur_r = '0;
                        exp_strobe = 0; exp_under = 1;
                     end
                     exp_ready = 1'b1;
                     $display("frame %0d start: L=%h R=%h strobe=%0d underrun=%0d",
                              frame_no, cur_l, cur_r, exp_strobe, exp_under);
                  end else begin
                     check($sformatf("strobe_count_f%0d", frame_no), 32'(strobe_cnt), 32'(exp_strobe));
                     check($sformatf("underrun_count_f%0d", frame_no), 32'(under_cnt), 32'(exp_under));
                  end
                  have_prev  = 1'b1;
                  prev_frame = frame_no;
                  prev_slot  = s;
               end
               cur_slot = s;
               cur_bit  = b;
               -> ev_fall;
               repeat (8) tick();
               check($sformatf("dacdat_f%0d_s%0d_b%0d", frame_no, s, b), 32'(aud_dacdat),
                     32'(exp_bit((s == 0) ? cur_l : cur_r, b)));
               check($sformatf("ready_f%0d_s%0d_b%0d", frame_no, s, b), 32'(sample_ready), 32'(exp_ready));
               cap = {cap[30:0], aud_dacdat};
               aud_bclk = 1'b1;
               repeat (7) tick();
            end
         end
      end
   end

   task automatic wait_fall(input int s, input int b, input int fr);
      int guard = 0;
      do begin
         @(ev_fall);
         guard++;
      end while (!(cur_slot == s && cur_bit == b && (fr < 0 || frame_no == fr)) && guard < 1000);
      check($sformatf("wait_fall_s%0d_b%0d", s, b), 32'(guard < 1000), 32'd1);
   endtask

   // Called at a negedge; presents one pair for one cycle.
   task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
      check("ready_before_send", 32'(sample_ready), 32'd1);
      audio_in_left  = l;
      audio_in_right = r;
      sample_valid   = 1'b1;
      pend_valid     = 1'b1;
      pend_l         = l;
      pend_r         = r;
      exp_ready      = 1'b0;
      @(negedge clk_50mhz);
      sample_valid = 1'b0;
      check("ready_after_send", 32'(sample_ready), 32'd0);
      $display("send pair L=%h R=%h", l, r);
   endtask

   initial begin : stim
      reset_n        = 1'b0;
      sample_valid   = 1'b0;
      audio_in_left  = '0;
      audio_in_right = '0;
      repeat (3) @(negedge clk_50mhz);
      check("reset_dacdat", 32'(aud_dacdat), 32'd0);
      check("reset_ready", 32'(sample_ready), 32'd1);
      check("reset_strobe", 32'(frame_strobe), 32'd0);
      check("reset_underrun", 32'(underrun), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk_50mhz);
      send_pair(16'h8001, 16'h7FFE);
      codec_run = 1'b1;

      // Frames 1 and 2 starve; frame 3 is fed in the lr_fall detection cycle.
      wait_fall(1, 10, 2);
      pend_valid = 1'b1;
      pend_l     = 16'hA5A5;
      pend_r     = 16'h5A5A;
      wait_fall(0, 0, 3);
      repeat (2) @(negedge clk_50mhz);
      audio_in_left  = 16'hA5A5;
      audio_in_right = 16'h5A5A;
      sample_valid   = 1'b1;
      @(negedge clk_50mhz);
      sample_valid = 1'b0;
      check("bypass_strobe", 32'(frame_strobe), 32'd1);
      check("bypass_underrun", 32'(underrun), 32'd0);
      check("bypass_ready", 32'(sample_ready), 32'd1);
      $display("bypass pair L=a5a5 R=5a5a");

      for (int n = 1; n <= 8; n++) begin
         wait_fall(0, 10, -1);
         send_pair(16'(n), 16'(-n));
      end
      wait_fall(0, 10, -1);
      send_pair(16'hFFFF, 16'hFFFF);

      wait_fall(0, 5, 12);
      send_pair(16'h5555, 16'h5555);
      wait_fall(0, 10, 12);
      check("pre_reset_dacdat", 32'(aud_dacdat), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_reset_dacdat", 32'(aud_dacdat), 32'd0);
      check("async_reset_ready", 32'(sample_ready), 32'd1);
      check("async_reset_strobe", 32'(frame_strobe), 32'd0);
      cur_l      = '0;
      cur_r      = '0;
      pend_valid = 1'b0;
      exp_ready  = 1'b1;
      $display("reset pulse mid left slot of frame 12");
      repeat (3) @(negedge clk_50mhz);
      reset_n = 1'b1;

      wait_fall(1, 10, 12);
      send_pair(16'h1234, 16'hABCD);
      wait_fall(0, 0, 14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
